// File: rtl/rom_loader_qspi_writer_if.sv
// Loader handshake plus QSPI SRAM pin bundle for rom_loader_qspi_writer.
// Ports (all in the interface):
//   rom_loader_reset/load/data       : loader requests toward the writer
//   rom_loader_load_received/ack     : one-cycle handshake pulses from the writer
//   busy, word_count                 : writer status
//   rom_cs_n/sck/sio_oe/sio_o        : quad SPI pins of the ROM SRAM
// master = loader side, slave = writer side.
interface rom_loader_qspi_writer_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16
);
  logic                     rom_loader_reset;
  logic                     rom_loader_load;
  logic [DATA_WIDTH-1:0]    rom_loader_data;
  logic                     rom_loader_load_received;
  logic                     rom_loader_ack;
  logic                     busy;
  logic [ADDRESS_WIDTH-1:0] word_count;
  logic                     rom_cs_n;
  logic                     rom_sck;
  logic                     rom_sio_oe;
  logic [3:0]               rom_sio_o;

  modport master (
    output rom_loader_reset, rom_loader_load, rom_loader_data,
    input  rom_loader_load_received, rom_loader_ack, busy, word_count,
    input  rom_cs_n, rom_sck, rom_sio_oe, rom_sio_o
  );

  modport slave (
    input  rom_loader_reset, rom_loader_load, rom_loader_data,
    output rom_loader_load_received, rom_loader_ack, busy, word_count,
    output rom_cs_n, rom_sck, rom_sio_oe, rom_sio_o
  );
endinterface

// File: rtl/rom_loader_qspi_writer.sv
// Writes each instruction word offered by the ROM loader into consecutive
// word locations of a QSPI serial SRAM that is already in quad mode.
// One SQI write per word: opcode (2 nibbles), 24-bit byte address
// (6 nibbles), data (DATA_WIDTH/4 nibbles), each nibble held two cycles
// (sck low, then sck high).
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : rom_loader_qspi_writer_if slave modport (handshake + SRAM pins)
module rom_loader_qspi_writer #(
  parameter int         DATA_WIDTH    = 16,
  parameter int         ADDRESS_WIDTH = 16,
  parameter logic [7:0] WRITE_CMD     = 8'h02
) (
  input logic                     clk,
  input logic                     reset,
  rom_loader_qspi_writer_if.slave bus
);
  localparam int SW  = 32 + DATA_WIDTH;  // opcode + address + data bits
  localparam int NIB = SW / 4;
  localparam int IW  = $clog2(NIB);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_END  = 3'd4,
    S_ACK  = 3'd5
  } state_t;

  state_t                   r_state, w_state_nx;
  logic [SW-1:0]            r_shift, w_shift_nx, w_shifted, w_stream;
  logic [IW-1:0]            r_idx, w_idx_nx, w_idx_inc;
  logic                     r_phase, w_phase_nx;
  logic [ADDRESS_WIDTH-1:0] r_wc, w_wc_nx;
  logic                     r_cs_n, w_cs_n_nx;
  logic                     r_sck, w_sck_nx;
  logic                     r_oe, w_oe_nx;
  logic [3:0]               r_sio, w_sio_nx;
  logic                     r_rcv, w_rcv_nx;
  logic                     r_ack, w_ack_nx;

  // Streaming sub-state is purely a function of which nibble is on the bus.
  function automatic state_t stream_state(input logic [IW-1:0] idx);
    if (idx < IW'(2)) begin
      return S_CMD;
    end else if (idx < IW'(8)) begin
      return S_ADDR;
    end else begin
      return S_DATA;
    end
  endfunction

  // Whole write frame is built at capture time so the address is frozen.
  assign w_stream = {WRITE_CMD, 24'({r_wc, 1'b0}), bus.rom_loader_data};

  // Next-state and next-output logic of the write sequencer.
  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_idx_nx   = r_idx;
    w_phase_nx = r_phase;
    w_wc_nx    = r_wc;
    w_cs_n_nx  = r_cs_n;
    w_sck_nx   = r_sck;
    w_oe_nx    = r_oe;
    w_sio_nx   = r_sio;
    w_rcv_nx   = 1'b0;
    w_ack_nx   = 1'b0;
    w_shifted  = r_shift << 4;
    w_idx_inc  = r_idx + IW'(1);
    case (r_state)
      S_IDLE: begin
        if (bus.rom_loader_load) begin
          w_state_nx = S_CMD;
          w_shift_nx = w_stream;
          w_idx_nx   = {IW{1'b0}};
          w_phase_nx = 1'b0;
          w_cs_n_nx  = 1'b0;
          w_sck_nx   = 1'b0;
          w_oe_nx    = 1'b1;
          w_sio_nx   = w_stream[SW-1 -: 4];
          w_rcv_nx   = 1'b1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_CMD, S_ADDR, S_DATA: begin
        if (!r_phase) begin
          // Second half of the nibble: raise sck, SRAM samples on this edge.
          w_sck_nx   = 1'b1;
          w_phase_nx = 1'b1;
        end else if (r_idx == IW'(NIB - 1)) begin
          w_state_nx = S_END;
          w_cs_n_nx  = 1'b1;
          w_sck_nx   = 1'b0;
          w_oe_nx    = 1'b0;
          w_sio_nx   = 4'h0;
          w_phase_nx = 1'b0;
        end else begin
          w_state_nx = stream_state(w_idx_inc);
          w_idx_nx   = w_idx_inc;
          w_shift_nx = w_shifted;
          w_sio_nx   = w_shifted[SW-1 -: 4];
          w_sck_nx   = 1'b0;
          w_phase_nx = 1'b0;
        end
      end
      S_END: begin
        w_state_nx = S_ACK;
        w_ack_nx   = 1'b1;
      end
      S_ACK: begin
        w_state_nx = S_IDLE;
        w_wc_nx    = r_wc + ADDRESS_WIDTH'(1);
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cs_n_nx  = 1'b1;
        w_sck_nx   = 1'b0;
        w_oe_nx    = 1'b0;
        w_sio_nx   = 4'h0;
      end
    endcase
  end

  // State and output registers; either reset source wins over a load.
  always_ff @(posedge clk) begin
    if (reset || bus.rom_loader_reset) begin
      r_state <= S_IDLE;
      r_shift <= {SW{1'b0}};
      r_idx   <= {IW{1'b0}};
      r_phase <= 1'b0;
      r_wc    <= {ADDRESS_WIDTH{1'b0}};
      r_cs_n  <= 1'b1;
      r_sck   <= 1'b0;
      r_oe    <= 1'b0;
      r_sio   <= 4'h0;
      r_rcv   <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_shift <= w_shift_nx;
      r_idx   <= w_idx_nx;
      r_phase <= w_phase_nx;
      r_wc    <= w_wc_nx;
      r_cs_n  <= w_cs_n_nx;
      r_sck   <= w_sck_nx;
      r_oe    <= w_oe_nx;
      r_sio   <= w_sio_nx;
      r_rcv   <= w_rcv_nx;
      r_ack   <= w_ack_nx;
    end
  end

  assign bus.rom_loader_load_received = r_rcv;
  assign bus.rom_loader_ack           = r_ack;
  assign bus.busy                     = (r_state != S_IDLE);
  assign bus.word_count               = r_wc;
  assign bus.rom_cs_n                 = r_cs_n;
  assign bus.rom_sck                  = r_sck;
  assign bus.rom_sio_oe               = r_oe;
  assign bus.rom_sio_o                = r_sio;
endmodule

// File: tb/tb_rom_loader_qspi_writer.sv
// Bench for rom_loader_qspi_writer. Two instances run in lockstep on the
// same stimulus: dut_a with a 16-bit word address, dut_b with a 2-bit word
// address so the address wrap shows up within a few writes.
module tb_rom_loader_qspi_writer;
  localparam int DW  = 16;
  localparam int NIB = 8 + DW / 4;
  localparam logic [5:0] ST_IDLE = 6'b001000;  // {rcv,ack,cs_n,sck,oe,busy}

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic          rl_reset;
  logic [DW-1:0] data;
  int            checks = 0;
  int            errors = 0;
  int            wc_a = 0;
  int            wc_b = 0;

  rom_loader_qspi_writer_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(16)) ifa ();
  rom_loader_qspi_writer_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(2))  ifb ();

  assign ifa.rom_loader_load  = load;
  assign ifa.rom_loader_data  = data;
  assign ifa.rom_loader_reset = rl_reset;
  assign ifb.rom_loader_load  = load;
  assign ifb.rom_loader_data  = data;
  assign ifb.rom_loader_reset = rl_reset;

  rom_loader_qspi_writer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(16), .WRITE_CMD(8'h02)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  rom_loader_qspi_writer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(2), .WRITE_CMD(8'h02)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  always #5 clk = ~clk;

  logic [5:0] st_a, st_b;
  assign st_a = {ifa.rom_loader_load_received, ifa.rom_loader_ack, ifa.rom_cs_n,
                 ifa.rom_sck, ifa.rom_sio_oe, ifa.busy};
  assign st_b = {ifb.rom_loader_load_received, ifb.rom_loader_ack, ifb.rom_cs_n,
                 ifb.rom_sck, ifb.rom_sio_oe, ifb.busy};

  // Reference: nibble k of the SQI write frame for word address wc.
  function automatic logic [3:0] nibble(input int wc, input logic [DW-1:0] d, input int k);
    logic [47:0] s;
    s = {8'h02, 24'(wc * 2), d};
    return s[47 - 4 * k -: 4];
  endfunction

  // One write. busy_at: cycle (after T0) of a stray load pulse, 0 = none.
  // abort_at: cycle of an abort, 0 = none; hard selects reset+load instead
  // of rom_loader_reset.
  task automatic run_write(input logic [DW-1:0] d, input int busy_at,
                           input int abort_at, input bit hard);
    logic [5:0] exp_st;
    bit         aborted;
    aborted = 1'b0;
    load = 1'b1;
    data = d;
    @(posedge clk); #1;  // T0
    load = 1'b0;
    data = DW'($urandom);
    for (int c = 1; c <= 2 * NIB + 2; c++) begin
      if (c == busy_at) begin
        load = 1'b1;
        data = {DW{1'b1}};
      end
      if (c == abort_at) begin
        if (hard) begin
          reset = 1'b1;
          load  = 1'b1;
        end else begin
          rl_reset = 1'b1;
        end
      end
      @(negedge clk);
      if (c <= 2 * NIB) begin
        exp_st    = 6'b000011;
        exp_st[5] = (c == 1);
        exp_st[2] = ((c - 1) % 2 == 1);
        checks++;
        if (ifa.rom_sio_o !== nibble(wc_a, d, (c - 1) / 2)) begin
          $display("FAIL sio_a cycle %0d got %h want %h", c, ifa.rom_sio_o, nibble(wc_a, d, (c - 1) / 2));
          errors++;
        end
        checks++;
        if (ifb.rom_sio_o !== nibble(wc_b, d, (c - 1) / 2)) begin
          $display("FAIL sio_b cycle %0d got %h want %h", c, ifb.rom_sio_o, nibble(wc_b, d, (c - 1) / 2));
          errors++;
        end
      end else if (c == 2 * NIB + 1) begin
        exp_st = 6'b001001;
      end else begin
        exp_st = 6'b011001;
      end
      checks++;
      if (st_a !== exp_st || st_b !== exp_st) begin
        $display("FAIL status cycle %0d got a=%b b=%b want %b", c, st_a, st_b, exp_st);
        errors++;
      end
      checks++;
      if (ifa.word_count !== 16'(wc_a) || ifb.word_count !== 2'(wc_b)) begin
        $display("FAIL wc_during cycle %0d got a=%0d b=%0d want a=%0d b=%0d",
                 c, ifa.word_count, ifb.word_count, wc_a, wc_b % 4);
        errors++;
      end
      @(posedge clk); #1;
      load = 1'b0;
      if (c == abort_at) begin
        rl_reset = 1'b0;
        reset    = 1'b0;
        aborted  = 1'b1;
        break;
      end
    end
    if (aborted) begin
      wc_a = 0;
      wc_b = 0;
      @(negedge clk);
      checks++;
      if (st_a !== ST_IDLE || st_b !== ST_IDLE || ifa.rom_sio_o !== 4'h0 ||
          ifa.word_count !== 16'h0000 || ifb.word_count !== 2'b00) begin
        $display("FAIL abort_state got st_a=%b st_b=%b sio=%h wc=%0d want st=%b sio=0 wc=0",
                 st_a, st_b, ifa.rom_sio_o, ifa.word_count, ST_IDLE);
        errors++;
      end
      for (int i = 0; i < 2 * NIB + 4; i++) begin
        @(negedge clk);
        checks++;
        if (st_a[5:4] !== 2'b00 || st_b[5:4] !== 2'b00) begin
          $display("FAIL abort_no_ack got rcv/ack a=%b b=%b want 00", st_a[5:4], st_b[5:4]);
          errors++;
        end
      end
    end else begin
      wc_a = (wc_a + 1) % 65536;
      wc_b = (wc_b + 1) % 4;
      @(negedge clk);
      checks++;
      if (st_a !== ST_IDLE || st_b !== ST_IDLE ||
          ifa.word_count !== 16'(wc_a) || ifb.word_count !== 2'(wc_b)) begin
        $display("FAIL write_done got st_a=%b wc_a=%0d wc_b=%0d want st=%b wc_a=%0d wc_b=%0d",
                 st_a, ifa.word_count, ifb.word_count, ST_IDLE, wc_a, wc_b);
        errors++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (st_a !== ST_IDLE || st_b !== ST_IDLE || ifa.rom_sio_o !== 4'h0 ||
        ifb.rom_sio_o !== 4'h0 || ifa.word_count !== 16'h0000 || ifb.word_count !== 2'b00) begin
      $display("FAIL reset got st_a=%b st_b=%b sio=%h wc=%0d want st=%b sio=0 wc=0",
               st_a, st_b, ifa.rom_sio_o, ifa.word_count, ST_IDLE);
      errors++;
    end
    reset = 1'b0;
  endtask

  task automatic test_single_and_second();
    run_write(16'hABCD, 0, 0, 1'b0);
    checks++;
    if (ifa.word_count !== 16'd1) begin
      $display("FAIL single_wc got %0d want 1", ifa.word_count);
      errors++;
    end
    run_write(16'h1234, 0, 0, 1'b0);
    checks++;
    if (ifa.word_count !== 16'd2) begin
      $display("FAIL second_wc got %0d want 2", ifa.word_count);
      errors++;
    end
  endtask

  task automatic test_busy_ignored();
    run_write(DW'($urandom), 5, 0, 1'b0);
    run_write(DW'($urandom), 17, 0, 1'b0);
  endtask

  task automatic test_abort();
    run_write(DW'($urandom), 0, 10, 1'b0);
    run_write(DW'($urandom), 0, 0, 1'b0);
  endtask

  task automatic test_reset_wins();
    load     = 1'b1;
    rl_reset = 1'b1;
    data     = DW'($urandom);
    @(posedge clk); #1;
    load     = 1'b0;
    rl_reset = 1'b0;
    wc_a = 0;
    wc_b = 0;
    @(negedge clk);
    checks++;
    if (st_a !== ST_IDLE || st_b !== ST_IDLE || ifa.word_count !== 16'h0000) begin
      $display("FAIL reset_wins got st_a=%b st_b=%b wc=%0d want st=%b wc=0",
               st_a, st_b, ifa.word_count, ST_IDLE);
      errors++;
    end
  endtask

  task automatic test_wrap();
    int seq [5] = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      run_write(DW'($urandom), 0, 0, 1'b0);
      checks++;
      if (ifb.word_count !== 2'(seq[i])) begin
        $display("FAIL wrap_seq write %0d got %0d want %0d", i, ifb.word_count, seq[i]);
        errors++;
      end
    end
  endtask

  task automatic test_reset_priority();
    run_write(DW'($urandom), 0, 20, 1'b1);
    run_write(DW'($urandom), 0, 0, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    rl_reset = 1'b0;
    data     = {DW{1'b0}};
    test_reset();
    test_single_and_second();
    test_busy_ignored();
    test_abort();
    test_reset_wins();
    test_wrap();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_loader_qspi_writer.md
# rom_loader_qspi_writer

Responder end of the SoC ROM-loading handshake: accepts instruction words presented by the loader (`rom_loader_load`/`rom_loader_data`), acknowledges them, and writes each word to consecutive locations of the external QSPI serial SRAM that holds the Hack ROM. It sits inside `hack_soc` on the ROM QSPI pins and drives them only while the CPU is held in `hack_external_reset`. The external arbitration mux is not part of this block. The SRAM is already in SQI (quad) mode when this block runs.

## Interface
- `DATA_WIDTH`, 16: instruction width in bits. Must be a multiple of 4.
- `ADDRESS_WIDTH`, 16: word-address width. Must be ≤ 23.
- `WRITE_CMD`, 8'h02: SRAM write opcode.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `reset`  in  1  synchronous, active-high.
- `rom_loader_reset`  in  1  synchronous. Clears the word address and aborts any transfer.
- `rom_loader_load`  in  1  loader request. Data is valid while high.
- `rom_loader_data`  in  DATA_WIDTH  word to write.
- `rom_loader_load_received`  out  1  one-cycle pulse when the word has been captured.
- `rom_loader_ack`  out  1  one-cycle pulse when the SRAM write is complete.
- `busy`  out  1  high in every state except IDLE.
- `word_count`  out  ADDRESS_WIDTH  address of the next word to be written.
- `rom_cs_n`  out  1  SRAM chip select, active low.
- `rom_sck`  out  1  SRAM serial clock.
- `rom_sio_oe`  out  1  output enable for the SIO lines.
- `rom_sio_o`  out  4  quad data out. Bit 3 maps to SIO3.

## Operation
- Reset values (applied by `reset` or `rom_loader_reset`): `rom_cs_n`=1, `rom_sck`=0, `rom_sio_oe`=0, `rom_sio_o`=0, both pulses 0, `busy`=0, `word_count`=0, state IDLE.
- States: IDLE, CMD, ADDR, DATA, END, ACK.
- **IDLE**: `rom_loader_load`=1 sampled, with `rom_loader_reset`=0, latches `rom_loader_data` and goes to CMD. All other inputs are ignored.
- **Nibble stream**, MSB-first:
  - CMD: 2 nibbles of `WRITE_CMD`.
  - ADDR: 6 nibbles of the 24-bit byte address = zero-extended {`word_count`, 1'b0}.
  - DATA: DATA_WIDTH/4 nibbles of the latched word.
- Each nibble lasts 2 cycles:
  - Phase 0: `rom_sio_o` shows the nibble, `rom_sck`=0.
  - Phase 1: same nibble, `rom_sck`=1. The SRAM samples on the rising edge.
- **END**: one cycle with `rom_cs_n`=1, `rom_sck`=0, `rom_sio_oe`=0.
- **ACK**: one cycle with `rom_loader_ack`=1. On exit, `word_count` increments, wrapping from 2^ADDRESS_WIDTH−1 to 0. Then IDLE.
- Loader rule: `rom_loader_load` must drop after `load_received` and must not rise again before `ack`. If it is still high when IDLE is re-entered, a new transfer starts. That is the loader's error and is not filtered.
- A `rom_loader_load` pulse while `busy` is ignored. Data is not re-sampled.
- `rom_loader_reset` mid-transfer: the next cycle shows the reset values. The partial SRAM write is abandoned. The next accepted word goes to address 0.
- `rom_loader_reset` and `rom_loader_load` high together: reset wins and the load is not accepted.

## Timing
- T0 = the edge where IDLE samples `rom_loader_load`=1. With N = 8 + DATA_WIDTH/4 (12 by default):
  - Cycle T0+1: `load_received`=1, `rom_cs_n`=0, `rom_sio_oe`=1, first nibble phase 0.
  - Nibble k (0..N−1) occupies cycles T0+1+2k and T0+2+2k.
  - Last `rom_sck` high: cycle T0+2N (T0+24).
  - END: cycle T0+2N+1.
  - ACK: cycle T0+2N+2 (T0+26).
  - IDLE: cycle T0+2N+3. Earliest next capture edge is at the end of that cycle.
- Throughput: one word per 2N+3 cycles (27 by default).
- `rom_sio_o`, `rom_sck` and `rom_cs_n` are registered outputs. `rom_cs_n` falls with the first phase 0 and rises only in END. `rom_sck` is 0 whenever `rom_cs_n`=1.

## Test plan
- **Single write.** After reset, load 16'hABCD for 1 cycle.
  - `load_received` at T0+1.
  - Nibbles 0,2,0,0,0,0,0,0,A,B,C,D, 12 `rom_sck` rising edges.
  - `rom_cs_n` high at T0+25, `ack` at T0+26, `word_count`=1.
- **Second write.** Load 16'h1234 after the ack.
  - Address nibbles 0,0,0,0,0,2. Data nibbles 1,2,3,4. `word_count`=2.
- **Busy load ignored.** Pulse load with 16'hFFFF at T0+5 of a transfer.
  - Data nibbles unchanged. Exactly one `load_received` and one `ack`.
- **Abort.** Assert `rom_loader_reset` at T0+10.
  - Next cycle: `rom_cs_n`=1, `rom_sio_oe`=0, `word_count`=0. No `ack`.
  - A subsequent write uses address nibbles all 0.
- **Wrap.** With ADDRESS_WIDTH=2, write 5 words.
  - Byte addresses 0,2,4,6,0. `word_count` sequence 1,2,3,0,1.
- **Reset priority.** `reset` during DATA with load held high and `rom_loader_reset`=0.
  - Every output shows its reset value the next cycle. No `load_received` in that cycle.
